bram_64_arb: RTL and testbench

//  Two-requester round-robin arbiter sharing the 64-bit port 'a' of the 8KB bram_64_8 buffer.

---
 rtl/bram_64_arb.sv | 156 +++++++++++++++
 tb/tb_bram_64_arb.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_64_arb.sv
// ---------------------------------------------------------------------------
// bram_64_arb
//   Round-robin arbiter that lets two requesters share the 64-bit port 'a' of
//   the bram_64_8 buffer. One requester owns the port at a time; an owner may
//   issue up to MAX_BURST back-to-back beats before ownership is re-arbitrated.
//   Read data comes straight from the BRAM, with a per-requester valid strobe
//   raised one cycle after the read beat to match the BRAM read latency.
//
// Ports
//   clk_in, rst_in                 clock and synchronous active-high reset
//   reqN_in                        requester N wants the port (one beat per
//                                  cycle while reqN_in && gntN_out)
//   weN_in / addrN_in / wr_dN_in   requester N byte enables (0 = read),
//                                  word address and write data
//   gntN_out                       requester N owns the port (registered)
//   rd_validN_out                  rd_d_out carries requester N read data
//   rd_d_out                       shared read data (= bram_rd_d_in)
//   bram_*_out / bram_rd_d_in      connection to BRAM port 'a'
// ---------------------------------------------------------------------------
module bram_64_arb #(
    parameter int MAX_BURST = 16,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 64,
    parameter int WE_W      = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              req0_in,
    input  logic [WE_W-1:0]   we0_in,
    input  logic [ADDR_W-1:0] addr0_in,
    input  logic [DATA_W-1:0] wr_d0_in,
    output logic              gnt0_out,
    output logic              rd_valid0_out,
    input  logic              req1_in,
    input  logic [WE_W-1:0]   we1_in,
    input  logic [ADDR_W-1:0] addr1_in,
    input  logic [DATA_W-1:0] wr_d1_in,
    output logic              gnt1_out,
    output logic              rd_valid1_out,
    output logic [DATA_W-1:0] rd_d_out,
    output logic              bram_en_out,
    output logic [WE_W-1:0]   bram_we_out,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic [DATA_W-1:0] bram_wr_d_out,
    input  logic [DATA_W-1:0] bram_rd_d_in
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beatCnt_q, beatCnt_d;
    logic               lastOwner_q, lastOwner_d;
    logic               rdValid0_q, rdValid0_d;
    logic               rdValid1_q, rdValid1_d;

    logic               ownerIs1;
    logic               granted;
    logic               ownerReq;
    logic               otherReq;
    logic               beat;
    logic               burstEnd;
    logic [WE_W-1:0]    ownerWe;
    logic [ADDR_W-1:0]  ownerAddr;
    logic [DATA_W-1:0]  ownerWrD;

    assign ownerIs1  = (state_q == GNT1);
    assign granted   = (state_q == GNT0) || (state_q == GNT1);
    assign ownerReq  = ownerIs1 ? req1_in  : req0_in;
    assign otherReq  = ownerIs1 ? req0_in  : req1_in;
    assign ownerWe   = ownerIs1 ? we1_in   : we0_in;
    assign ownerAddr = ownerIs1 ? addr1_in : addr0_in;
    assign ownerWrD  = ownerIs1 ? wr_d1_in : wr_d0_in;
    assign burstEnd  = (beatCnt_q == CNT_W'(MAX_BURST - 1));

    // A beat is suppressed in the reset cycle so no access reaches the BRAM
    // while the arbiter is being cleared.
    assign beat = granted && ownerReq && !rst_in;

    // Next-state logic. Leaving a grant (request dropped or burst exhausted)
    // hands straight to the other requester if it is waiting; otherwise the
    // arbiter drops to IDLE, which is what forces the one-cycle gap when a
    // lone requester hits its burst limit.
    always_comb begin
        state_d     = state_q;
        beatCnt_d   = beatCnt_q;
        lastOwner_d = lastOwner_q;
        unique case (state_q)
            IDLE: begin
                if (req0_in && (!req1_in || lastOwner_q)) begin
                    state_d = GNT0;
                end else if (req1_in) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!ownerReq || burstEnd) begin
                    if (otherReq) begin
                        state_d = ownerIs1 ? GNT0 : GNT1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    beatCnt_d = beatCnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Any ownership change restarts the beat count; entering a grant
        // records the new owner for the next tie-break.
        if (state_d != state_q) begin
            beatCnt_d = '0;
            if (state_d == GNT0) lastOwner_d = 1'b0;
            if (state_d == GNT1) lastOwner_d = 1'b1;
        end
    end

    assign rdValid0_d = beat && !ownerIs1 && (ownerWe == '0);
    assign rdValid1_d = beat &&  ownerIs1 && (ownerWe == '0);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            beatCnt_q   <= '0;
            lastOwner_q <= 1'b1;
            rdValid0_q  <= 1'b0;
            rdValid1_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beatCnt_q   <= beatCnt_d;
            lastOwner_q <= lastOwner_d;
            rdValid0_q  <= rdValid0_d;
            rdValid1_q  <= rdValid1_d;
        end
    end

    assign gnt0_out = (state_q == GNT0);
    assign gnt1_out = (state_q == GNT1);

    // A read issued just before reset returns its data during the reset
    // cycle; masking here discards that response.
    assign rd_valid0_out = rdValid0_q && !rst_in;
    assign rd_valid1_out = rdValid1_q && !rst_in;
    assign rd_d_out      = bram_rd_d_in;

    assign bram_en_out   = beat;
    assign bram_we_out   = beat ? ownerWe   : '0;
    assign bram_addr_out = beat ? ownerAddr : '0;
    assign bram_wr_d_out = beat ? ownerWrD  : '0;

endmodule

// File: tb/tb_bram_64_arb.sv
// ---------------------------------------------------------------------------
// tb_bram_64_arb
//   Drives both requesters of bram_64_arb through reset, single reads, burst
//   limiting, contention, byte writes and reset mid-burst. A behavioural BRAM
//   sits on port 'a'; a cycle model predicts grants and BRAM drive, and a
//   queue holds the expected read data until the matching valid strobe.
// ---------------------------------------------------------------------------
module tb_bram_64_arb;

    localparam int MAXB = 16;

    typedef struct packed {
        logic        req;
        logic [63:0] data;
    } sbItem_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [7:0]  we0, we1;
    logic [9:0]  addr0, addr1;
    logic [63:0] wrD0, wrD1;
    logic        gnt0Out, gnt1Out, rdValid0Out, rdValid1Out;
    logic [63:0] rdDOut;
    logic        bramEn;
    logic [7:0]  bramWe;
    logic [9:0]  bramAddr;
    logic [63:0] bramWrD;
    logic [63:0] bramRdD;

    logic        tbLoad;
    logic [63:0] mem    [0:1023];
    logic [63:0] shadow [0:1023];
    sbItem_t     sb[$];

    int          mState;
    int          mCnt;
    logic        mLast, mRdv0, mRdv1;
    logic        beat0Seen, beat1Seen;
    int          obsBeat0, obsBeat1, obsRv0, obsRv1;
    logic [63:0] lastRd1;

    int          nCompared = 0;
    int          nMismatch = 0;

    always #5 clk = ~clk;

    bram_64_arb #(.MAX_BURST(MAXB), .ADDR_W(10), .DATA_W(64), .WE_W(8)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .req0_in       (req0),
        .we0_in        (we0),
        .addr0_in      (addr0),
        .wr_d0_in      (wrD0),
        .gnt0_out      (gnt0Out),
        .rd_valid0_out (rdValid0Out),
        .req1_in       (req1),
        .we1_in        (we1),
        .addr1_in      (addr1),
        .wr_d1_in      (wrD1),
        .gnt1_out      (gnt1Out),
        .rd_valid1_out (rdValid1Out),
        .rd_d_out      (rdDOut),
        .bram_en_out   (bramEn),
        .bram_we_out   (bramWe),
        .bram_addr_out (bramAddr),
        .bram_wr_d_out (bramWrD),
        .bram_rd_d_in  (bramRdD)
    );

    function automatic logic [63:0] patt(input int i);
        logic [31:0] hi, lo;
        hi = 32'hC0DE_0000 + 32'(i);
        lo = 32'h5A5A_0000 ^ (32'(i) * 32'd3);
        return {hi, lo};
    endfunction

    // Behavioural BRAM port 'a': byte-enabled write, one-cycle registered read.
    always @(posedge clk) begin
        if (tbLoad) begin
            for (int i = 0; i < 1024; i++) mem[i] <= patt(i);
        end else if (bramEn) begin
            for (int b = 0; b < 8; b++) begin
                if (bramWe[b]) mem[bramAddr][b*8 +: 8] <= bramWrD[b*8 +: 8];
            end
            bramRdD <= mem[bramAddr];
        end
    end

    task automatic check1(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatch++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic [7:0] w0, input logic [9:0] a0,
                                 input logic [63:0] d0, input logic r1, input logic [7:0] w1,
                                 input logic [9:0] a1, input logic [63:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wrD0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wrD1 = d1;
    endtask

    // Compare this cycle's DUT outputs with the model, then advance the model
    // across the coming clock edge.
    task automatic checkOutput();
        logic        expG0, expG1, ownerIs1, beat, myReq, otherReq;
        logic [7:0]  oWe;
        logic [9:0]  oAddr;
        logic [63:0] oData;
        sbItem_t     item;
        expG0    = (mState == 1);
        expG1    = (mState == 2);
        ownerIs1 = expG1;
        myReq    = ownerIs1 ? req1 : req0;
        otherReq = ownerIs1 ? req0 : req1;
        beat     = !rst && (expG0 || expG1) && myReq;
        oWe      = ownerIs1 ? we1   : we0;
        oAddr    = ownerIs1 ? addr1 : addr0;
        oData    = ownerIs1 ? wrD1  : wrD0;

        check1("gnt0",      64'(gnt0Out),     64'(expG0));
        check1("gnt1",      64'(gnt1Out),     64'(expG1));
        check1("bram_en",   64'(bramEn),      64'(beat));
        check1("bram_we",   64'(bramWe),      beat ? 64'(oWe)   : 64'd0);
        check1("bram_addr", 64'(bramAddr),    beat ? 64'(oAddr) : 64'd0);
        check1("bram_wr_d", bramWrD,          beat ? oData      : 64'd0);
        check1("rd_valid0", 64'(rdValid0Out), 64'(mRdv0 && !rst));
        check1("rd_valid1", 64'(rdValid1Out), 64'(mRdv1 && !rst));

        if (mRdv0 || mRdv1) begin
            check1("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                item = sb.pop_front();
                if (!rst) begin
                    check1("rd_owner", 64'(rdValid1Out), 64'(item.req));
                    check1("rd_data",  rdDOut,           item.data);
                end
            end
        end

        if (bramEn && gnt0Out) obsBeat0++;
        if (bramEn && gnt1Out) obsBeat1++;
        if (rdValid0Out) obsRv0++;
        if (rdValid1Out) begin
            obsRv1++;
            lastRd1 = rdDOut;
        end

        beat0Seen = beat && !ownerIs1;
        beat1Seen = beat && ownerIs1;
        if (beat) begin
            if (oWe == 8'h00) begin
                item.req  = ownerIs1;
                item.data = shadow[oAddr];
                sb.push_back(item);
            end else begin
                for (int b = 0; b < 8; b++) begin
                    if (oWe[b]) shadow[oAddr][b*8 +: 8] = oData[b*8 +: 8];
                end
            end
        end

        if (rst) begin
            mState = 0; mCnt = 0; mLast = 1'b1; mRdv0 = 1'b0; mRdv1 = 1'b0;
        end else begin
            mRdv0 = beat && !ownerIs1 && (oWe == 8'h00);
            mRdv1 = beat &&  ownerIs1 && (oWe == 8'h00);
            if (mState == 0) begin
                if (req0 && (!req1 || mLast)) begin
                    mState = 1; mLast = 1'b0; mCnt = 0;
                end else if (req1) begin
                    mState = 2; mLast = 1'b1; mCnt = 0;
                end
            end else if (!myReq || mCnt == MAXB - 1) begin
                mCnt = 0;
                if (otherReq) begin
                    mState = ownerIs1 ? 1 : 2;
                    mLast  = !ownerIs1;
                end else begin
                    mState = 0;
                end
            end else begin
                mCnt++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic clearCounts();
        obsBeat0 = 0; obsBeat1 = 0; obsRv0 = 0; obsRv1 = 0;
    endtask

    initial begin
        int          beats;
        int          guard;
        logic [63:0] expRd;

        mState = 0; mCnt = 0; mLast = 1'b1; mRdv0 = 1'b0; mRdv1 = 1'b0;
        beat0Seen = 1'b0; beat1Seen = 1'b0; lastRd1 = '0;
        clearCounts();
        for (int i = 0; i < 1024; i++) shadow[i] = patt(i);

        // Load the BRAM model and bring the arbiter into reset.
        rst = 1'b1; tbLoad = 1'b1;
        applyStimulus(1'b1, 8'h00, 10'h000, 64'd0, 1'b1, 8'h00, 10'h000, 64'd0);
        @(posedge clk);
        #1;
        tbLoad = 1'b0;

        $display("[TB] reset held with both requests high");
        repeat (2) tick();
        check1("reset_no_beats", 64'(obsBeat0 + obsBeat1), 64'd0);

        $display("[TB] single reader 0x010..0x013");
        rst = 1'b0;
        clearCounts();
        beats = 0; guard = 0;
        while (beats < 4 && guard < 20) begin
            applyStimulus(1'b1, 8'h00, 10'h010 + 10'(beats), 64'd0, 1'b0, 8'h00, 10'h000, 64'd0);
            tick();
            if (beat0Seen) beats++;
            guard++;
        end
        applyStimulus(1'b0, 8'h00, 10'h000, 64'd0, 1'b0, 8'h00, 10'h000, 64'd0);
        repeat (2) tick();
        check1("single_beats",   64'(obsBeat0), 64'd4);
        check1("single_rvalid0", 64'(obsRv0),   64'd4);
        check1("single_rvalid1", 64'(obsRv1),   64'd0);

        $display("[TB] burst cap with req0 alone for 40 cycles");
        clearCounts();
        for (int c = 0; c < 40; c++) begin
            applyStimulus(1'b1, 8'h00, 10'h100 + 10'(c), 64'd0, 1'b0, 8'h00, 10'h000, 64'd0);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 10'h000, 64'd0, 1'b0, 8'h00, 10'h000, 64'd0);
        repeat (2) tick();
        check1("burst_beats",   64'(obsBeat0), 64'd37);
        check1("burst_rvalid0", 64'(obsRv0),   64'd37);

        $display("[TB] contention from reset: req0 reads, req1 writes");
        rst = 1'b1;
        applyStimulus(1'b1, 8'h00, 10'h000, 64'd0, 1'b1, 8'hFF, 10'h000, 64'd0);
        tick();
        rst = 1'b0;
        clearCounts();
        for (int c = 0; c < 65; c++) begin
            applyStimulus(1'b1, 8'h00, 10'h200 + 10'(c) - 10'd16, 64'd0,
                          1'b1, 8'hFF, 10'h200 + 10'(c), 64'hD000_0000_0000_0000 | 64'(c));
            tick();
        end
        applyStimulus(1'b0, 8'h00, 10'h000, 64'd0, 1'b0, 8'h00, 10'h000, 64'd0);
        repeat (2) tick();
        check1("contend_beats0",  64'(obsBeat0), 64'd32);
        check1("contend_beats1",  64'(obsBeat1), 64'd32);
        check1("contend_rvalid0", 64'(obsRv0),   64'd32);
        check1("contend_rvalid1", 64'(obsRv1),   64'd0);

        $display("[TB] byte write then read at 0x3FF");
        clearCounts();
        guard = 0;
        applyStimulus(1'b0, 8'h00, 10'h000, 64'd0, 1'b1, 8'h0F, 10'h3FF, 64'h1122334455667788);
        tick();
        while (!beat1Seen && guard < 10) begin
            tick();
            guard++;
        end
        applyStimulus(1'b0, 8'h00, 10'h000, 64'd0, 1'b1, 8'h00, 10'h3FF, 64'd0);
        tick();
        guard = 0;
        while (!beat1Seen && guard < 10) begin
            tick();
            guard++;
        end
        applyStimulus(1'b0, 8'h00, 10'h000, 64'd0, 1'b0, 8'h00, 10'h000, 64'd0);
        repeat (2) tick();
        expRd = patt(10'h3FF);
        expRd = {expRd[63:32], 32'h5566_7788};
        check1("bytewr_beats",   64'(obsBeat1), 64'd2);
        check1("bytewr_rvalid1", 64'(obsRv1),   64'd1);
        check1("bytewr_data",    lastRd1,       expRd);

        $display("[TB] reset after read beat 5");
        clearCounts();
        beats = 0; guard = 0;
        while (beats < 5 && guard < 20) begin
            applyStimulus(1'b1, 8'h00, 10'h040 + 10'(beats), 64'd0, 1'b0, 8'h00, 10'h000, 64'd0);
            tick();
            if (beat0Seen) beats++;
            guard++;
        end
        rst = 1'b1;
        tick();
        check1("midrst_rvalid0", 64'(obsRv0), 64'd4);
        rst = 1'b0;
        clearCounts();
        repeat (3) tick();
        check1("midrst_regrant_beats", 64'(obsBeat0), 64'd2);
        applyStimulus(1'b0, 8'h00, 10'h000, 64'd0, 1'b0, 8'h00, 10'h000, 64'd0);
        repeat (2) tick();
        check1("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
